hex_scan_driver: RTL

Time-multiplexed 8-digit seven-segment display driver that consumes the 32-bit `hex_dec` result word produced by the `device` datapath and scans it onto a shared-segment, common-anode display on the board. Values are taken on a load strobe, double-buffered, and applied only at frame boundaries so a digit never shows a mix of old and new values. It sits between `device` and the board pins in the top level.

---
 rtl/seg7_pkg.sv | 41 ++++
 rtl/hex_to_seg7.sv | 17 +
 rtl/hex_scan_driver.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and types for the seven-segment scan driver.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Holds the active-low segment code table, the blank/none patterns for the
// segment and anode buses, and small helpers shared by the scan logic.
package seg7_pkg;

    // Number of digit positions on the board display.
    localparam int DIGITS = 8;

    // All segments off (active low) and no anode driven (active low).
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [7:0] SEL_NONE  = 8'hFF;

    // Active-low segment codes, bit order {g,f,e,d,c,b,a}, indexed by nibble.
    // Listed from nibble F down to nibble 0 so that index k selects digit k.
    localparam logic [15:0][6:0] SEG_CODES = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E D C
        7'h03, 7'h08, 7'h10, 7'h00,   // B A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

    typedef logic [3:0]                nibble_t;
    typedef logic [$clog2(DIGITS)-1:0] idx_t;

    // One output frame of the display pins: segments plus anode selects.
    typedef struct packed {
        logic [6:0] led;
        logic [7:0] sel;
    } disp_t;

    localparam disp_t DISP_OFF = '{led: SEG_BLANK, sel: SEL_NONE};

    // Active-low one-hot anode select for digit position i.
    function automatic logic [7:0] sel_onehot_low(input idx_t i);
        return ~(8'h01 << i);
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Nibble to seven-segment decoder (active-low outputs, {g,f,e,d,c,b,a}).
// Latency: combinational, zero cycles.
// Backpressure: none; pure lookup.
//
// Ports:
//   nibble  in  4  hex digit value 0..F
//   seg     out 7  active-low segment pattern for that digit
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG_CODES[nibble];

endmodule

// File: rtl/hex_scan_driver.sv
// Time-multiplexed 8-digit common-anode seven-segment driver with frame-aligned double buffering.
// Latency: outputs registered, one cycle behind idx/act_q/digit_en_i; a load shows within 8*SCAN_DIV+1 cycles.
// Backpressure: none; loads are never refused, a later load before the frame boundary replaces an earlier one.
//
// Ports:
//   clk_i       in  1   system clock
//   reset       in  1   synchronous active-high reset
//   hex_i       in  32  value to display, nibble k drives digit k (digit 0 rightmost)
//   load_i      in  1   single-cycle capture strobe for hex_i
//   digit_en_i  in  8   per-digit enable, 0 forces that digit blank
//   hex_led_o   out 7   active-low segments {g,f,e,d,c,b,a}
//   hex_sel_o   out 8   active-low digit anodes, one-hot-low when lit
//   pending_o   out 1   a loaded value is waiting for the next frame boundary
module hex_scan_driver
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV = 100000,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic        clk_i,
    input  logic        reset,
    input  logic [31:0] hex_i,
    input  logic        load_i,
    input  logic [7:0]  digit_en_i,
    output logic [6:0]  hex_led_o,
    output logic [7:0]  hex_sel_o,
    output logic        pending_o
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam idx_t IDX_LAST = idx_t'(DIGITS - 1);

    // ------------------------------------------------------------------
    // Prescaler and digit index
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] presc_q;
    idx_t             idx_q;
    logic             tick;
    logic             frame_wrap;

    assign tick       = (presc_q == CNT_LAST);
    assign frame_wrap = tick && (idx_q == IDX_LAST);

    always_ff @(posedge clk_i) begin
        if (reset) begin
            presc_q <= '0;
        end else if (tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + CNT_W'(1);
        end
    end

    // idx_q is exactly three bits wide, so 7 -> 0 wraps naturally.
    always_ff @(posedge clk_i) begin
        if (reset) begin
            idx_q <= '0;
        end else if (tick) begin
            idx_q <= idx_q + idx_t'(1);
        end
    end

    // ------------------------------------------------------------------
    // Double buffer: pend_q collects loads, act_q changes only at the
    // frame boundary so no frame mixes two values.
    // ------------------------------------------------------------------
    logic [31:0] pend_q;
    logic [31:0] act_q;
    logic        pend_v;

    always_ff @(posedge clk_i) begin
        if (reset) begin
            pend_q <= '0;
            act_q  <= '0;
            pend_v <= 1'b0;
        end else if (load_i && frame_wrap) begin
            // A load landing on the boundary bypasses the pending stage;
            // any older pending value is superseded by this newer one.
            act_q  <= hex_i;
            pend_v <= 1'b0;
        end else if (load_i) begin
            pend_q <= hex_i;
            pend_v <= 1'b1;
        end else if (frame_wrap && pend_v) begin
            act_q  <= pend_q;
            pend_v <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Blanking
    // upper_zero[k] is set when nibbles k..7 of act_q are all zero, so a
    // digit is a leading zero exactly when its own upper_zero bit is set.
    // ------------------------------------------------------------------
    logic [DIGITS-1:0] upper_zero;
    logic [DIGITS-1:0] blank_mask;

    always_comb begin
        upper_zero = '0;
        upper_zero[DIGITS-1] = (act_q[4*(DIGITS-1) +: 4] == 4'h0);
        for (int k = DIGITS - 2; k >= 0; k--) begin
            upper_zero[k] = upper_zero[k+1] && (act_q[4*k +: 4] == 4'h0);
        end
    end

    always_comb begin
        blank_mask = '0;
        for (int k = 0; k < DIGITS; k++) begin
            // Digit 0 always shows something so a zero value reads as "0".
            blank_mask[k] = !digit_en_i[k] || (BLANK_LZ && (k != 0) && upper_zero[k]);
        end
    end

    // ------------------------------------------------------------------
    // Segment decode of the currently scanned nibble
    // ------------------------------------------------------------------
    nibble_t    cur_nibble;
    logic [6:0] cur_seg;

    assign cur_nibble = act_q[{idx_q, 2'b00} +: 4];

    hex_to_seg7 u_hex_to_seg7 (
        .nibble (cur_nibble),
        .seg    (cur_seg)
    );

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    disp_t disp_d;
    disp_t disp_q;

    always_comb begin
        disp_d = DISP_OFF;
        if (!blank_mask[idx_q]) begin
            disp_d.led = cur_seg;
            disp_d.sel = sel_onehot_low(idx_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset) begin
            disp_q <= DISP_OFF;
        end else begin
            disp_q <= disp_d;
        end
    end

    assign hex_led_o = disp_q.led;
    assign hex_sel_o = disp_q.sel;
    assign pending_o = pend_v;

endmodule
